// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB master.
// Converts a command/response handshake into APB SETUP/ACCESS transfers.
// It honours PREADY wait states and aborts an ACCESS phase that stalls for
// TIMEOUT consecutive cycles (TIMEOUT = 0 disables the abort).
//
// Handshake rules:
//   - A command is accepted on a PCLK edge where CMD_VALID & CMD_READY.
//     CMD_READY is high only in IDLE and never while PRESET is high.
//   - RSP_VALID is a one-cycle pulse with no back-pressure. RSP_ERR and
//     RSP_RDATA are meaningful only in that cycle.
//   - The APB side follows IDLE -> SETUP -> ACCESS (with waits) -> IDLE.
//     At least one PSEL-low cycle always separates two transfers.
module apb_initiator #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [DWIDTH-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [DWIDTH-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  output logic [1:0]        dbg_state
);

  // The counter is sized to hold TIMEOUT. With the timeout disabled it keeps
  // one bit and saturates, so it never wraps.
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  // Abort in the last allowed stalled ACCESS cycle. The ACCESS phase then
  // lasts exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);

  // Ready is decoded straight from the state register. It is gated by reset
  // so that nothing is accepted while PRESET is high.
  assign CMD_READY = (state == ST_IDLE) && !PRESET;
  assign dbg_state = state;

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CMD_VALID) begin
            // Write data is loaded on reads as well, which keeps the datapath simple.
            PADDR    <= CMD_ADDR;
            PWRITE   <= CMD_WRITE;
            PWDATA   <= CMD_WDATA;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            wait_cnt <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            if (!PWRITE) begin
              RSP_RDATA <= PRDATA;
            end
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= ST_IDLE;
          end else if (timeout_hit) begin
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b1;
            RSP_VALID <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= ST_IDLE;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: self-checking bench for apb_initiator with TIMEOUT=4.
// It contains an APB slave memory model with configurable wait states and a
// stuck-PREADY mode, a scoreboard of expected responses, and a protocol monitor.
module tb_apb_initiator;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic          CMD_WRITE = 1'b0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [DW-1:0] CMD_WDATA = '0;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_RDATA;
  logic          RSP_ERR;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic [1:0]    dbg_state;

  apb_initiator #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  // Free-running cycle counter for latency measurement.
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave model ----------------
  logic [DW-1:0] mem [256];
  logic          mem_clr = 1'b1;
  int            wait_cfg = 0;
  logic          stuck = 1'b0;
  int            wctr = 0;

  assign PREADY = !stuck && (wctr >= wait_cfg);
  assign PRDATA = mem[PADDR];

  // Slave: counts wait cycles inside ACCESS and commits writes on completion.
  always @(posedge PCLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      wctr <= 0;
    end else begin
      if (PSEL && PENABLE && !PREADY) wctr <= wctr + 1;
      else                            wctr <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        is_write;
    logic        err;
    logic [7:0]  rdata;
    logic [7:0]  lat;
    logic [7:0]  acc_len;
    logic [31:0] acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  logic [DW-1:0] ref_mem [256];
  logic          cur_exp_err = 1'b0;
  int            acc_run = 0;
  int            rsp_count = 0;
  logic          b2b = 1'b0;
  logic          have_last = 1'b0;
  int            last_acc = 0;
  int            viol = 0;
  logic          p_rst = 1'b1;
  logic          p_psel = 1'b0, p_penable = 1'b0, p_write = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;

  // Monitor: pops and compares responses, pushes expectations on accept and
  // checks APB protocol rules on every cycle.
  always @(negedge PCLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    end
    if (PRESET) begin
      acc_run = 0;
    end else begin
      if (PSEL && PENABLE) acc_run++;
      if (RSP_VALID) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(RSP_VALID), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_err", 32'(RSP_ERR), 32'(e.err));
          if (!e.is_write) check("rsp_rdata", 32'(RSP_RDATA), 32'(e.rdata));
          check("rsp_latency", 32'(cyc) - e.acc_cyc, 32'(e.lat));
          check("access_len", 32'(acc_run), 32'(e.acc_len));
        end
        acc_run = 0;
      end
      if (CMD_VALID && CMD_READY) begin
        if (b2b && have_last) check("b2b_period", 32'(cyc - last_acc), 32'd3);
        last_acc  = cyc;
        have_last = 1'b1;
        e.is_write = CMD_WRITE;
        e.err      = cur_exp_err;
        e.rdata    = cur_exp_err ? 8'h00 : ref_mem[CMD_ADDR];
        e.lat      = cur_exp_err ? 8'(2 + TO) : 8'(3 + wait_cfg);
        e.acc_len  = cur_exp_err ? 8'(TO) : 8'(wait_cfg + 1);
        e.acc_cyc  = 32'(cyc);
        exp_q.push_back(e);
        if (CMD_WRITE && !cur_exp_err) ref_mem[CMD_ADDR] = CMD_WDATA;
      end
      if (!p_rst) begin
        if (PENABLE && !PSEL) viol++;
        if (PSEL && PENABLE && !p_psel) viol++;
        if (PSEL && !PENABLE && p_psel) viol++;
        if (PSEL && p_psel && (PADDR != p_addr || PWDATA != p_wdata || PWRITE != p_write)) viol++;
        if (!PSEL && !p_psel && (PADDR != p_addr || PWDATA != p_wdata || PWRITE != p_write)) viol++;
      end
    end
    p_rst     = PRESET;
    p_psel    = PSEL;
    p_penable = PENABLE;
    p_addr    = PADDR;
    p_wdata   = PWDATA;
    p_write   = PWRITE;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n;
    CMD_VALID = 1'b1;
    CMD_WRITE = w;
    CMD_ADDR  = a;
    CMD_WDATA = d;
    n = 0;
    @(negedge PCLK);
    while (!CMD_READY && n < 50) begin
      n++;
      @(negedge PCLK);
    end
    if (!CMD_READY) check("accept_timeout", 32'(CMD_READY), 32'd1);
    @(posedge PCLK);
    #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_missing", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic       stuck;
    logic       exp_err;
  } vec_t;

  vec_t tbl[11];
  int   rc0;

  // Main test sequence.
  initial begin
    tbl[0]  = '{1'b0, 8'h12, 8'h00, 0, 1'b0, 1'b0};  // read after write
    tbl[1]  = '{1'b1, 8'h34, 8'h5A, 3, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h34, 8'h00, 3, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h56, 8'hC3, 1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h56, 8'h00, 2, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h12, 8'h00, 0, 1'b1, 1'b1};  // timeout read
    tbl[6]  = '{1'b0, 8'h34, 8'h00, 0, 1'b0, 1'b0};  // recovers normally
    tbl[7]  = '{1'b1, 8'h78, 8'h0F, 0, 1'b1, 1'b1};  // timeout write, not stored
    tbl[8]  = '{1'b0, 8'h78, 8'h00, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'hFF, 8'h99, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'hFF, 8'h00, 1, 1'b0, 1'b0};

    // Clock and reset block.
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("ready_in_reset", 32'(CMD_READY), 32'd0);
    @(posedge PCLK);
    #1;
    PRESET  = 1'b0;
    mem_clr = 1'b0;
    @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", 32'(PWDATA), 32'd0);
    check("rst_rsp", {22'd0, RSP_VALID, RSP_ERR, RSP_RDATA}, 32'd0);
    check("rst_ready", 32'(CMD_READY), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Hand sequence: zero-wait write with per-phase checks.
    @(posedge PCLK);
    #1;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 8'h12; CMD_WDATA = 8'hA5;
    @(negedge PCLK);
    check("idle_ready", 32'(CMD_READY), 32'd1);
    @(posedge PCLK);
    #1;
    CMD_VALID = 1'b0;
    @(negedge PCLK);
    check("setup_sel_en", {30'd0, PSEL, PENABLE}, 32'b10);
    check("setup_addr_data", {16'd0, PADDR, PWDATA}, 32'h12A5);
    check("setup_ready", 32'(CMD_READY), 32'd0);
    check("setup_state", 32'(dbg_state), 32'd1);
    @(negedge PCLK);
    check("access_sel_en", {30'd0, PSEL, PENABLE}, 32'b11);
    check("access_addr_data", {15'd0, PWRITE, PADDR, PWDATA}, 32'h112A5);
    check("access_state", 32'(dbg_state), 32'd2);
    wait_idle();

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      wait_cfg    = tbl[i].waits;
      stuck       = tbl[i].stuck;
      cur_exp_err = tbl[i].exp_err;
      send(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      wait_idle();
    end

    // Random traffic over a small address window.
    stuck = 1'b0;
    cur_exp_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_cfg = $urandom_range(0, 3);
      send(1'($urandom_range(0, 1)), 8'($urandom_range(8'h40, 8'h43)), 8'($urandom_range(0, 255)));
      wait_idle();
    end

    // Back-to-back: 8 commands with CMD_VALID held high.
    wait_cfg  = 0;
    b2b       = 1'b1;
    have_last = 1'b0;
    rc0       = rsp_count;
    for (int i = 0; i < 8; i++) begin
      send(1'(i % 2), 8'(8'h60 + (i / 2)), 8'(8'h10 * i + 3));
    end
    wait_idle();
    b2b = 1'b0;
    check("b2b_rsp_count", 32'(rsp_count - rc0), 32'd8);

    // Reset in the middle of a stalled ACCESS phase.
    stuck       = 1'b1;
    cur_exp_err = 1'b1;
    rc0         = rsp_count;
    send(1'b1, 8'h21, 8'h77);
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    check("midrst_ready_low", 32'(CMD_READY), 32'd0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    stuck  = 1'b0;
    cur_exp_err = 1'b0;
    exp_q.delete();
    @(negedge PCLK);
    check("midrst_sel_en", {30'd0, PSEL, PENABLE}, 32'd0);
    check("midrst_addr_data", {15'd0, PWRITE, PADDR, PWDATA}, 32'd0);
    check("midrst_rsp", {22'd0, RSP_VALID, RSP_ERR, RSP_RDATA}, 32'd0);
    check("midrst_ready", 32'(CMD_READY), 32'd1);
    repeat (6) @(negedge PCLK);
    check("midrst_no_rsp", 32'(rsp_count - rc0), 32'd0);
    @(posedge PCLK);
    #1;
    send(1'b0, 8'h21, 8'h00);  // aborted write was never committed
    wait_idle();
    send(1'b1, 8'h22, 8'h3C);
    wait_idle();
    send(1'b0, 8'h22, 8'h00);
    wait_idle();

    check("protocol_violations", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

Synthesizable single-outstanding APB master that turns a simple command/response handshake into APB read and write transfers. It is the initiator counterpart of the team's APB slave models and sits between test/processor logic and an APB slave segment. It honours PREADY wait states and aborts hung transfers with a programmable timeout. It never holds PSEL for more than SETUP plus ACCESS cycles, so the slave-model protocol checkers stay clean.

## Interface
Parameters:
- AWIDTH, 8, PADDR/CMD_ADDR width
- DWIDTH, 8, data width
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY at PCLK edge
- CMD_WRITE  in  1  1=write, 0=read
- CMD_ADDR  in  AWIDTH  transfer address
- CMD_WDATA  in  DWIDTH  write data
- RSP_VALID  out  1  one-cycle pulse: transfer finished
- RSP_RDATA  out  DWIDTH  read data (valid with RSP_VALID on reads)
- RSP_ERR  out  1  timeout abort flag (valid with RSP_VALID)
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  AWIDTH; PWDATA  out  DWIDTH
- PRDATA  in  DWIDTH; PREADY  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0, CMD_READY=1 (0 while PRESET=1). On accept, register PADDR<=CMD_ADDR, PWRITE<=CMD_WRITE, PWDATA<=CMD_WDATA (loaded on reads too), go to SETUP.
- SETUP: PSEL=1, PENABLE=0, CMD_READY=0; next state is always ACCESS.
- ACCESS: PSEL=1, PENABLE=1. If PREADY=1: capture RSP_RDATA<=PRDATA on reads (unchanged on writes), RSP_ERR<=0, RSP_VALID<=1, go to IDLE. If PREADY=0: stay in ACCESS and increment the wait counter.
- Timeout (TIMEOUT>0): when the wait counter shows PREADY low for TIMEOUT consecutive ACCESS cycles, go to IDLE with RSP_VALID<=1, RSP_ERR<=1, RSP_RDATA<=0. Wait counter clears on entry to SETUP. Counter width is clog2(TIMEOUT+1); it must not wrap.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the last ACCESS cycle, and hold their values in IDLE until the next accept.
- There is never a direct ACCESS->SETUP transition. At least one IDLE cycle with PSEL=0 separates transfers.
- RSP_VALID is a one-cycle pulse. There is no response back-pressure; the consumer must take it.
- Reset values: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, wait counter 0.
- Reset mid-transfer: PSEL and PENABLE go to 0 at the edge where PRESET is sampled high. No RSP_VALID is produced for the aborted transfer.
- Inputs are ignored while PRESET=1.

## Timing
- Accept at edge N (end of IDLE cycle). Cycle N+1 is SETUP; cycle N+2 is ACCESS.
- Zero wait states: RSP_VALID=1 in cycle N+3, and the FSM is back in IDLE with CMD_READY=1.
- With k wait cycles, RSP_VALID is in cycle N+3+k.
- Back-to-back throughput: one transfer per 3 cycles (IDLE, SETUP, ACCESS). A new command held valid during the RSP_VALID cycle is accepted in that cycle.
- Timeout: the ACCESS phase lasts exactly TIMEOUT cycles; RSP_VALID/RSP_ERR appear in cycle N+2+TIMEOUT.
- All outputs are registered except CMD_READY, which is decoded from the state register.

## Test plan
- Write, zero wait: CMD_WRITE=1, ADDR=0x12, WDATA=0xA5, PREADY=1. Required: PSEL=1/PENABLE=0 in N+1, PSEL=1/PENABLE=1 in N+2, PADDR=0x12 and PWDATA=0xA5 stable in both, RSP_VALID=1 with RSP_ERR=0 in N+3.
- Read after write: read ADDR=0x12 against the APB slave model. Required: RSP_RDATA=0xA5 with RSP_VALID in N+3, and no protocol-violation messages from the slave model.
- Wait states: PREADY held low for 3 ACCESS cycles. Required: PENABLE high for 4 cycles, addr/data stable throughout, RSP_VALID in N+6.
- Timeout: TIMEOUT=4, PREADY stuck at 0. Required: ACCESS lasts 4 cycles, then RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0. The next command then completes normally with RSP_ERR=0.
- Back-to-back: 8 commands with CMD_VALID held high. Required: one transfer every 3 cycles, PSEL low exactly one cycle between transfers, 8 RSP_VALID pulses.
- Reset mid-ACCESS: PRESET=1 for one cycle during ACCESS with PREADY low. Required: all outputs at reset values on the next cycle, no RSP_VALID, CMD_READY=1 on the cycle after PRESET falls.
